// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, OR-ed stall sources,
// irq-priority flush and a saturating count of beats discarded by flushes.
module pipe_stage_skid_reg #(
  parameter int DATA_W  = 105,
  parameter int N_STALL = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_STALL-1:0] stall_req,
  input  logic               irq,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              hold, flush, in_fire, out_fire;
  logic [1:0]        flush_inc;
  logic [CNT_W+1:0]  flush_sum;
  logic [CNT_W-1:0]  flush_sat;

  assign hold      = (|stall_req) & ~irq;
  assign flush     = irq | clr;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign in_ready  = ~hold & ~(main_valid & skid_valid);
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : '0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready & ~hold;

  // A main beat taken downstream in the flush cycle is delivered, not discarded
  always_comb begin
    flush_inc = {1'b0, main_valid & ~out_fire} + {1'b0, skid_valid} + {1'b0, in_fire};
    flush_sum = {2'b00, flush_cnt} + {{CNT_W{1'b0}}, flush_inc};
    flush_sat = (flush_sum > {2'b00, CNT_MAX}) ? CNT_MAX : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      flush_cnt  <= '0;
    end else if (hold) begin
      main_valid <= main_valid;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      flush_cnt  <= flush_sat;
    end else if (out_fire && in_fire) begin
      // in_fire excludes FULL, so the skid entry is empty here
      main_data <= in_data;
    end else if (out_fire) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end
    end else if (in_fire) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W  = 105;
  localparam int N_STALL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_STALL-1:0] stall_req;
  logic              irq, clr, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [7:0]        flush_cnt;
  logic              s_in_ready, s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occ;
  logic [1:0]        s_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .N_STALL(N_STALL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .irq(irq), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .flush_cnt(flush_cnt));

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .N_STALL(N_STALL), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .irq(irq), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occ(s_occ), .flush_cnt(s_flush_cnt));

  int checks = 0;
  int passed = 0;
  bit model_known = 0;
  logic [DATA_W-1:0] q[$];
  int flushed_total = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic rn, input logic [N_STALL-1:0] st, input logic ir,
                               input logic cl, input logic iv, input logic [DATA_W-1:0] d,
                               input logic ordy);
    rst_n = rn; stall_req = st; irq = ir; clr = cl;
    in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // Drive one cycle: inputs at negedge, compare before the edge, advance the model
  task automatic runCycle(input logic rn, input logic [N_STALL-1:0] st, input logic ir,
                          input logic cl, input logic iv, input logic [DATA_W-1:0] d,
                          input logic ordy);
    bit hold, flush, infire, outfire, exp_ready;
    logic [DATA_W-1:0] exp_data;
    @(negedge clk);
    applyStimulus(rn, st, ir, cl, iv, d, ordy);
    #1;
    hold      = (st != '0) && !ir;
    flush     = ir || cl;
    exp_ready = !hold && (q.size() < 2);
    exp_data  = (q.size() > 0) ? q[0] : '0;
    infire    = iv && exp_ready;
    outfire   = (q.size() > 0) && ordy && !hold;
    if (model_known) begin
      checkOutput("in_ready",      128'(in_ready),    128'(exp_ready));
      checkOutput("out_valid",     128'(out_valid),   128'(q.size() > 0));
      checkOutput("out_data",      128'(out_data),    128'(exp_data));
      checkOutput("occ",           128'(occ),         128'(q.size()));
      checkOutput("flush_cnt",     128'(flush_cnt),   128'((flushed_total > 255) ? 255 : flushed_total));
      checkOutput("sat_flush_cnt", 128'(s_flush_cnt), 128'((flushed_total > 3) ? 3 : flushed_total));
      checkOutput("sat_occ",       128'(s_occ),       128'(q.size()));
      checkOutput("sat_out_data",  128'(s_out_data),  128'(exp_data));
      checkOutput("sat_in_ready",  128'(s_in_ready),  128'(exp_ready));
      checkOutput("sat_out_valid", 128'(s_out_valid), 128'(q.size() > 0));
    end
    if (!rn) begin
      q.delete();
      flushed_total = 0;
      model_known = 1;
    end else if (hold) begin
      flushed_total = flushed_total;
    end else if (flush) begin
      flushed_total += q.size() - int'(outfire) + int'(infire);
      q.delete();
    end else begin
      if (outfire) void'(q.pop_front());
      if (infire) q.push_back(d);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [127:0] r;
    logic [DATA_W-1:0] rd;
    logic [N_STALL-1:0] st;
    runCycle(0, '0, 0, 0, 0, '0, 0);
    runCycle(0, '0, 0, 0, 0, '0, 0);
    checkOutput("rst_occ", 128'(occ), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_out_data", 128'(out_data), 128'(0));
    checkOutput("rst_flush_cnt", 128'(flush_cnt), 128'(0));

    for (int i = 0; i < 8; i++) begin
      runCycle(1, '0, 0, 0, 1, DATA_W'(8'h11 + i), 1);
      checkOutput("stream_data", 128'(out_data), 128'(8'h11 + i));
      checkOutput("stream_ready", 128'(in_ready), 128'(1));
    end
    runCycle(1, '0, 0, 0, 0, '0, 1);

    runCycle(1, '0, 0, 0, 1, DATA_W'(8'h0A), 0);
    runCycle(1, '0, 0, 0, 1, DATA_W'(8'h0B), 0);
    checkOutput("bp_occ_full", 128'(occ), 128'(2));
    checkOutput("bp_ready_low", 128'(in_ready), 128'(0));
    checkOutput("bp_first", 128'(out_data), 128'(8'h0A));
    runCycle(1, '0, 0, 0, 0, '0, 1);
    checkOutput("bp_second", 128'(out_data), 128'(8'h0B));
    runCycle(1, '0, 0, 0, 0, '0, 1);
    checkOutput("bp_drained", 128'(occ), 128'(0));

    runCycle(1, '0, 0, 0, 1, DATA_W'(8'h55), 0);
    runCycle(1, 4'b0100, 0, 0, 1, DATA_W'(8'h66), 1);
    checkOutput("stall_occ", 128'(occ), 128'(1));
    checkOutput("stall_data", 128'(out_data), 128'(8'h55));
    checkOutput("stall_ready", 128'(in_ready), 128'(0));
    runCycle(1, 4'b0100, 1, 0, 0, '0, 0);
    checkOutput("irq_occ", 128'(occ), 128'(0));
    checkOutput("irq_cnt", 128'(flush_cnt), 128'(1));

    runCycle(1, '0, 0, 0, 1, DATA_W'(1), 0);
    runCycle(1, '0, 0, 0, 1, DATA_W'(2), 0);
    runCycle(1, '0, 0, 1, 1, DATA_W'(3), 0);
    checkOutput("clr_occ", 128'(occ), 128'(0));
    checkOutput("clr_cnt", 128'(flush_cnt), 128'(3));

    for (int i = 0; i < 4; i++) begin
      runCycle(1, '0, 0, 0, 1, DATA_W'(8'h70 + i), 0);
      runCycle(1, '0, 0, 1, 0, '0, 0);
    end
    checkOutput("sat_stuck", 128'(s_flush_cnt), 128'(3));
    checkOutput("cnt_after_sat", 128'(flush_cnt), 128'(7));

    runCycle(1, '0, 0, 0, 1, DATA_W'(8'h99), 0);
    runCycle(0, '0, 0, 0, 0, '0, 0);
    checkOutput("midrst_occ", 128'(occ), 128'(0));
    checkOutput("midrst_cnt", 128'(flush_cnt), 128'(0));

    for (int i = 0; i < 4000; i++) begin
      r  = {$urandom, $urandom, $urandom, $urandom};
      rd = r[DATA_W-1:0];
      st = ($urandom_range(0, 5) == 0) ? N_STALL'($urandom_range(1, 15)) : '0;
      runCycle(($urandom_range(0, 399) != 0), st, ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 9) == 0), 1'($urandom), rd, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
